rpn_calc_ctrl: RTL and testbench
================================

Name: rpn_calc_ctrl

Overview:
Sequencing controller for the reverse-Polish calculator. It takes the debounced enter/undo button levels and the 16-bit switch value, and steps through operand A, operand B, opcode and result. It drives the shared ALU operand and opcode inputs, and latches the ALU result and flags. It also selects the value sent to the 7-segment display driver. It sits between the debouncers and the ALU/display datapath.

Parameters:
DATA_W, 16, operand/result width
OP_W, 2, opcode width; opcode = data_in[OP_W-1:0]
MASK_OPCODE, 0, 1 -> opcode entry is rejected (no transition) unless data_in[DATA_W-1:OP_W]==0; 0 -> upper bits are ignored
BUTTON_EDGE, 0, 0 -> act on press (rising edge); 1 -> act on release (falling edge)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
enter  in  1  debounced enter button level
undo  in  1  debounced undo button level
data_in  in  DATA_W  switch value
alu_a  out  DATA_W  latched operand A to ALU
alu_b  out  DATA_W  latched operand B to ALU
alu_op  out  OP_W  opcode to ALU (live data_in bits in S_OP, latched otherwise)
alu_result  in  DATA_W  combinational ALU result
alu_flags  in  4  combinational ALU flags {N,Z,C,V}
display  out  DATA_W  value for 7-seg driver
flags  out  4  latched flags, zero outside S_RES
state  out  2  current state encoding (debug/LEDs)

Behaviour:
- Reset (rst high at a clk edge): state=S_A, alu_a=alu_b=0, op register=0, result register=0, flags=0, button history registers=0. Reset mid-sequence aborts it; no partial state is kept.
- Edge detect: btn_q<=btn every cycle. BUTTON_EDGE=0 gives ev=btn&~btn_q; BUTTON_EDGE=1 gives ev=~btn&btn_q. ev is combinational and is consumed on the same edge, so state changes 1 clk after the first sampled edge. A held button gives exactly one event.
- States: S_A=0, S_B=1, S_OP=2, S_RES=3.
- S_A: display=data_in. enter -> alu_a<=data_in, go to S_B. undo -> no-op.
- S_B: display=data_in. enter -> alu_b<=data_in, go to S_OP. undo -> S_A; alu_a is kept.
- S_OP: display=data_in; alu_op=data_in[OP_W-1:0] live.
  - enter (when accepted by MASK_OPCODE) -> op register<=alu_op, result<=alu_result, flags<=alu_flags, go to S_RES.
  - Rejected enter -> stay, nothing is latched.
  - undo -> S_B.
- S_RES: display=result register; flags output=flags register; alu_op=op register.
  - enter -> S_A; result and flags are cleared.
  - undo -> S_OP; flags output returns to 0.
- Simultaneous enter and undo events in one cycle: undo wins, enter is dropped.
- display and flags are combinational from state and registers, with no extra latency.
- Widths: no arithmetic in this block; all values pass through unmodified.
- Register updates happen only on events; data_in changes without an event have no effect except the live display and the live alu_op in S_OP.

Decomposition:
- Package rpn_ctrl_pkg: state_t enum (S_A, S_B, S_OP, S_RES), opcode constants (ADD=0, SUB=1, OR=2, AND=3), flag bit indices (N=3, Z=2, C=1, V=0).
- Sub-module btn_edge_detect (parameter EDGE; ports clk, rst, level, ev), instantiated twice.

Test Plan:
- Sequence:
  - rst 2 cycles, then press enter with data_in=0x1234 -> state=1, alu_a=0x1234.
  - Then enter with 0x0011 -> state=2, alu_b=0x0011.
  - Then enter with 0x0001 -> state=3.
  - Required: result latched from ALU, display=ALU value, flags=ALU flags.
- Undo chain: from S_RES, press undo 3x -> states 2,1,0; flags=0 after the first undo; further undo in S_A keeps state=0.
- Held button: enter held high 50 cycles in S_A -> exactly one transition (state=1). With BUTTON_EDGE=1 the transition occurs 1 clk after release instead.
- Simultaneous: enter and undo rise on the same cycle in S_OP -> state=1; result and flags unchanged.
- MASK_OPCODE=1: in S_OP with data_in=0x0102 and enter -> state stays 2. Then data_in=0x0002 and enter -> state=3, alu_op=2.
- Reset mid-operation: rst pulsed in S_OP with alu_a=0xAAAA -> next cycle state=0, alu_a=0, alu_b=0, flags=0, display=data_in.

Source files
------------

// File: rtl/rpn_calc_ctrl_pkg.sv
// ============================================================================
// Module      : rpn_ctrl_pkg
// Description : Shared types and constants for the RPN calculator controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rpn_ctrl_pkg;

    typedef enum logic [1:0] {
        S_A   = 2'd0,
        S_B   = 2'd1,
        S_OP  = 2'd2,
        S_RES = 2'd3
    } state_t;

    localparam logic [1:0] c_OP_ADD = 2'd0;
    localparam logic [1:0] c_OP_SUB = 2'd1;
    localparam logic [1:0] c_OP_OR  = 2'd2;
    localparam logic [1:0] c_OP_AND = 2'd3;

    localparam int c_FLAG_N = 3;
    localparam int c_FLAG_Z = 2;
    localparam int c_FLAG_C = 1;
    localparam int c_FLAG_V = 0;

endpackage

`default_nettype wire

// File: rtl/rpn_calc_ctrl_if.sv
// ============================================================================
// Module      : rpn_calc_ctrl_if
// Description : Operand/opcode/result bus between the controller and the ALU.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface rpn_calc_ctrl_if #(
    parameter int DATA_W = 16,
    parameter int OP_W   = 2
);
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [OP_W-1:0]   alu_op;
    logic [DATA_W-1:0] alu_result;
    logic [3:0]        alu_flags;

    modport master (
        output alu_a,
        output alu_b,
        output alu_op,
        input  alu_result,
        input  alu_flags
    );

    modport slave (
        input  alu_a,
        input  alu_b,
        input  alu_op,
        output alu_result,
        output alu_flags
    );
endinterface

`default_nettype wire

// File: rtl/rpn_calc_ctrl_btn_edge_detect.sv
// ============================================================================
// Module      : btn_edge_detect
// Description : One-cycle event on the chosen edge of a debounced button level.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module btn_edge_detect #(
    parameter bit EDGE = 1'b0
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic level,
    output logic      ev
);

    logic r_level_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_level_q <= 1'b0;
        end else begin
            r_level_q <= level;
        end
    end

    generate
        if (EDGE) begin : g_fall
            assign ev = ~level & r_level_q;
        end else begin : g_rise
            assign ev = level & ~r_level_q;
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/rpn_calc_ctrl.sv
// ============================================================================
// Module      : rpn_calc_ctrl
// Description : Operand A / operand B / opcode / result sequencer for the RPN calculator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rpn_calc_ctrl
    import rpn_ctrl_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int OP_W        = 2,
    parameter bit MASK_OPCODE = 1'b0,
    parameter bit BUTTON_EDGE = 1'b0
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              enter,
    input  wire logic              undo,
    input  wire logic [DATA_W-1:0] data_in,
    rpn_calc_ctrl_if.master        alu,
    output logic      [DATA_W-1:0] display,
    output logic      [3:0]        flags,
    output logic      [1:0]        state
);

    state_t            r_state;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [OP_W-1:0]   r_op;
    logic [DATA_W-1:0] r_res;
    logic [3:0]        r_flags;

    logic w_enter_ev;
    logic w_undo_ev;
    logic w_op_ok;

    btn_edge_detect #(.EDGE(BUTTON_EDGE)) u_enter_edge (
        .clk   (clk),
        .rst   (rst),
        .level (enter),
        .ev    (w_enter_ev)
    );

    btn_edge_detect #(.EDGE(BUTTON_EDGE)) u_undo_edge (
        .clk   (clk),
        .rst   (rst),
        .level (undo),
        .ev    (w_undo_ev)
    );

    generate
        if (MASK_OPCODE) begin : g_mask_op
            assign w_op_ok = (data_in[DATA_W-1:OP_W] == '0);
        end else begin : g_no_mask_op
            assign w_op_ok = 1'b1;
        end
    endgenerate

    // Undo takes priority: a simultaneous enter event is simply dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_A;
            r_a     <= '0;
            r_b     <= '0;
            r_op    <= '0;
            r_res   <= '0;
            r_flags <= '0;
        end else if (w_undo_ev) begin
            case (r_state)
                S_B:     r_state <= S_A;
                S_OP:    r_state <= S_B;
                S_RES:   r_state <= S_OP;
                default: r_state <= S_A;
            endcase
        end else if (w_enter_ev) begin
            case (r_state)
                S_A: begin
                    r_a     <= data_in;
                    r_state <= S_B;
                end
                S_B: begin
                    r_b     <= data_in;
                    r_state <= S_OP;
                end
                S_OP: begin
                    if (w_op_ok) begin
                        r_op    <= data_in[OP_W-1:0];
                        r_res   <= alu.alu_result;
                        r_flags <= alu.alu_flags;
                        r_state <= S_RES;
                    end
                end
                default: begin
                    r_res   <= '0;
                    r_flags <= '0;
                    r_state <= S_A;
                end
            endcase
        end
    end

    // The ALU sees the live switch opcode while it is being chosen.
    assign alu.alu_a  = r_a;
    assign alu.alu_b  = r_b;
    assign alu.alu_op = (r_state == S_OP) ? data_in[OP_W-1:0] : r_op;

    assign display = (r_state == S_RES) ? r_res : data_in;
    assign flags   = (r_state == S_RES) ? r_flags : 4'b0000;
    assign state   = r_state;

endmodule

`default_nettype wire

// File: tb/tb_rpn_calc_ctrl.sv
// ============================================================================
// Module      : tb_rpn_calc_ctrl
// Description : Two controller instances (press/no-mask and release/mask) vs. a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rpn_calc_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enter = 1'b0;
    logic        undo = 1'b0;
    logic [15:0] data_in = 16'h0;

    logic [15:0] disp0, disp1;
    logic [3:0]  flg0, flg1;
    logic [1:0]  st0, st1;

    int n_checks = 0;
    int n_err    = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    // Reference ALU: {N,Z,C,V, result}
    function automatic logic [19:0] alu_f(input logic [15:0] a, input logic [15:0] b,
                                          input logic [1:0] op);
        logic [16:0] s;
        logic        v;
        v = 1'b0;
        case (op)
            2'd0: begin
                s = {1'b0, a} + {1'b0, b};
                v = (a[15] == b[15]) && (s[15] != a[15]);
            end
            2'd1: begin
                s = {1'b0, a} - {1'b0, b};
                v = (a[15] != b[15]) && (s[15] != a[15]);
            end
            2'd2:    s = {1'b0, a | b};
            default: s = {1'b0, a & b};
        endcase
        return {s[15], (s[15:0] == 16'h0), s[16], v, s[15:0]};
    endfunction

    rpn_calc_ctrl_if #(.DATA_W(16), .OP_W(2)) if0 ();
    rpn_calc_ctrl_if #(.DATA_W(16), .OP_W(2)) if1 ();

    assign {if0.alu_flags, if0.alu_result} = alu_f(if0.alu_a, if0.alu_b, if0.alu_op);
    assign {if1.alu_flags, if1.alu_result} = alu_f(if1.alu_a, if1.alu_b, if1.alu_op);

    rpn_calc_ctrl #(.DATA_W(16), .OP_W(2), .MASK_OPCODE(1'b0), .BUTTON_EDGE(1'b0)) dut0 (
        .clk     (clk),
        .rst     (rst),
        .enter   (enter),
        .undo    (undo),
        .data_in (data_in),
        .alu     (if0),
        .display (disp0),
        .flags   (flg0),
        .state   (st0)
    );

    rpn_calc_ctrl #(.DATA_W(16), .OP_W(2), .MASK_OPCODE(1'b1), .BUTTON_EDGE(1'b1)) dut1 (
        .clk     (clk),
        .rst     (rst),
        .enter   (enter),
        .undo    (undo),
        .data_in (data_in),
        .alu     (if1),
        .display (disp1),
        .flags   (flg1),
        .state   (st1)
    );

    // Reference model, index 0 = press/no-mask, 1 = release/mask.
    bit          cfg_release[2] = '{1'b0, 1'b1};
    bit          cfg_mask[2]    = '{1'b0, 1'b1};
    int          m_st[2];
    logic [15:0] m_a[2], m_b[2], m_res[2];
    logic [1:0]  m_op[2];
    logic [3:0]  m_flg[2];
    bit          m_enq[2], m_unq[2];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step(input int i);
        bit          ev_e, ev_u;
        logic [19:0] r;
        if (rst) begin
            m_st[i] = 0; m_a[i] = 0; m_b[i] = 0; m_op[i] = 0;
            m_res[i] = 0; m_flg[i] = 0; m_enq[i] = 0; m_unq[i] = 0;
        end else begin
            ev_e = cfg_release[i] ? (!enter && m_enq[i]) : (enter && !m_enq[i]);
            ev_u = cfg_release[i] ? (!undo && m_unq[i]) : (undo && !m_unq[i]);
            if (ev_u) begin
                if (m_st[i] > 0) m_st[i] = m_st[i] - 1;
            end else if (ev_e) begin
                case (m_st[i])
                    0: begin m_a[i] = data_in; m_st[i] = 1; end
                    1: begin m_b[i] = data_in; m_st[i] = 2; end
                    2: begin
                        if (!cfg_mask[i] || (data_in >> 2) == 0) begin
                            r = alu_f(m_a[i], m_b[i], data_in[1:0]);
                            m_op[i] = data_in[1:0];
                            m_res[i] = r[15:0];
                            m_flg[i] = r[19:16];
                            m_st[i] = 3;
                        end
                    end
                    default: begin m_res[i] = 0; m_flg[i] = 0; m_st[i] = 0; end
                endcase
            end
            m_enq[i] = enter;
            m_unq[i] = undo;
        end
    endtask

    task automatic check_dut(input int i, input logic [1:0] st, input logic [15:0] a,
                             input logic [15:0] b, input logic [1:0] op,
                             input logic [15:0] disp, input logic [3:0] flg);
        check_val($sformatf("dut%0d.state", i), st, m_st[i]);
        check_val($sformatf("dut%0d.alu_a", i), a, m_a[i]);
        check_val($sformatf("dut%0d.alu_b", i), b, m_b[i]);
        check_val($sformatf("dut%0d.alu_op", i), op, (m_st[i] == 2) ? data_in[1:0] : m_op[i]);
        check_val($sformatf("dut%0d.display", i), disp, (m_st[i] == 3) ? m_res[i] : data_in);
        check_val($sformatf("dut%0d.flags", i), flg, (m_st[i] == 3) ? m_flg[i] : 4'h0);
    endtask

    task automatic cyc(input logic en, input logic un, input logic r, input logic [15:0] din);
        @(negedge clk);
        enter = en; undo = un; rst = r; data_in = din;
        #1;
        if (chk_en) begin
            check_dut(0, st0, if0.alu_a, if0.alu_b, if0.alu_op, disp0, flg0);
            check_dut(1, st1, if1.alu_a, if1.alu_b, if1.alu_op, disp1, flg1);
        end
        @(posedge clk);
        #1;
        model_step(0);
        model_step(1);
        if (r) chk_en = 1'b1;
    endtask

    // Press and release with steady data: both instances see one event.
    task automatic press_enter(input logic [15:0] din);
        cyc(1'b1, 1'b0, 1'b0, din);
        cyc(1'b0, 1'b0, 1'b0, din);
    endtask

    task automatic press_undo(input logic [15:0] din);
        cyc(1'b0, 1'b1, 1'b0, din);
        cyc(1'b0, 1'b0, 1'b0, din);
    endtask

    initial begin
        logic en_r, un_r;
        logic [15:0] d;

        cyc(1'b0, 1'b0, 1'b1, 16'h0);
        cyc(1'b0, 1'b0, 1'b1, 16'h0);
        check_val("rst_state", st0, 2'd0);
        check_val("rst_alu_a", if0.alu_a, 16'h0);
        check_val("rst_flags", flg0, 4'h0);

        press_enter(16'h1234);
        check_val("seq_a_state0", st0, 2'd1);
        check_val("seq_a_val0", if0.alu_a, 16'h1234);
        check_val("seq_a_state1", st1, 2'd1);
        press_enter(16'h0011);
        check_val("seq_b_state0", st0, 2'd2);
        check_val("seq_b_val0", if0.alu_b, 16'h0011);
        press_enter(16'h0001);
        check_val("seq_res_state0", st0, 2'd3);
        check_val("seq_res_disp0", disp0, 16'h1223);
        check_val("seq_res_state1", st1, 2'd3);

        press_undo(16'h0000);
        check_val("undo1_state", st0, 2'd2);
        check_val("undo1_flags", flg0, 4'h0);
        press_undo(16'h0000);
        check_val("undo2_state", st0, 2'd1);
        press_undo(16'h0000);
        check_val("undo3_state", st0, 2'd0);
        press_undo(16'h0000);
        check_val("undo4_state", st0, 2'd0);
        check_val("undo4_state1", st1, 2'd0);

        for (int k = 0; k < 50; k++) cyc(1'b1, 1'b0, 1'b0, 16'h00AA);
        check_val("held_state0", st0, 2'd1);
        check_val("held_state1", st1, 2'd0);
        cyc(1'b0, 1'b0, 1'b0, 16'h00AA);
        check_val("release_state1", st1, 2'd1);

        press_enter(16'h0022);
        check_val("op_state0", st0, 2'd2);
        cyc(1'b1, 1'b1, 1'b0, 16'h0003);
        cyc(1'b0, 1'b0, 1'b0, 16'h0003);
        check_val("simul_state0", st0, 2'd1);
        check_val("simul_state1", st1, 2'd1);
        check_val("simul_flags0", flg0, 4'h0);

        press_enter(16'h0033);
        press_enter(16'h0102);
        check_val("mask_rej_state1", st1, 2'd2);
        check_val("nomask_acc_state0", st0, 2'd3);
        check_val("nomask_disp0", disp0, 16'h00BB);
        press_enter(16'h0002);
        check_val("mask_acc_state1", st1, 2'd3);
        check_val("mask_acc_op1", if1.alu_op, 2'd2);
        check_val("mask_acc_disp1", disp1, 16'h00BB);

        cyc(1'b0, 1'b0, 1'b1, 16'h0000);
        press_enter(16'hAAAA);
        press_enter(16'h5555);
        check_val("mid_pre_a", if0.alu_a, 16'hAAAA);
        cyc(1'b0, 1'b0, 1'b1, 16'h0F0F);
        check_val("mid_rst_state", st0, 2'd0);
        check_val("mid_rst_a", if0.alu_a, 16'h0);
        check_val("mid_rst_b", if0.alu_b, 16'h0);
        check_val("mid_rst_flags", flg0, 4'h0);
        check_val("mid_rst_disp", disp0, 16'h0F0F);

        en_r = 1'b0;
        un_r = 1'b0;
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 99) < 30) en_r = ~en_r;
            if ($urandom_range(0, 99) < 12) un_r = ~un_r;
            d = 16'($urandom());
            if ($urandom_range(0, 1) == 0) d = {14'h0, d[1:0]};
            cyc(en_r, un_r, ($urandom_range(0, 199) == 0), d);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
